// File: rtl/afifo_pkg.sv
// Shared types for the async FIFO read side.
// Holds the skid buffer state encoding.
package afifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_st_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry registered skid buffer on the FIFO read port (rclk domain).
// Ports: rclk, rrst_n (async low), rempty/rdata in, rinc out,
// m_valid/m_data out, m_ready in, rd_cnt out when RD_CNT_EN is defined.
// Optional feature macro: RD_CNT_EN (downstream transfer counter).
module fifo_rd_skid
  import afifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready
`ifdef RD_CNT_EN
  ,
  output logic [CSIZE-1:0] rd_cnt
`endif
);

  if (CSIZE < 1) begin : g_csize_chk
    $error("fifo_rd_skid: CSIZE must be >= 1");
  end

  skid_st_t st, st_nx;
  logic [DSIZE-1:0] head, tail;
  logic push, pop;

  assign push = rinc;
  assign pop  = m_valid & m_ready;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) st <= EMPTY;
    else         st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      EMPTY: if (push) st_nx = ONE;
      ONE: begin
        if (push && !pop)      st_nx = TWO;
        else if (pop && !push) st_nx = EMPTY;
      end
      TWO: if (pop) st_nx = ONE;
      default: st_nx = EMPTY;
    endcase
  end

  // rrst_n gating keeps the FIFO from popping into a buffer
  // that is being cleared.
  always_comb begin
    rinc    = rrst_n & ~rempty & (st != TWO);
    m_valid = (st != EMPTY);
    m_data  = head;
  end

  // Head always holds the oldest word; tail only fills
  // when the head is blocked.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (st)
        EMPTY: if (push) head <= rdata;
        ONE: begin
          if (push && !pop)     tail <= rdata;
          else if (push && pop) head <= rdata;
        end
        TWO: if (pop) head <= tail;
        default: ;
      endcase
    end
  end

`ifdef RD_CNT_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)  rd_cnt <= '0;
    else if (pop) rd_cnt <= rd_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_skid.sv
// Directed/random bench for fifo_rd_skid with a FIFO model.
// Honours RD_CNT_EN (instance built with CSIZE=4 to hit the wrap).
module tb_fifo_rd_skid;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
`ifdef RD_CNT_EN
  logic [3:0] rd_cnt;
`endif

  fifo_rd_skid #(
    .DSIZE(8)
`ifdef RD_CNT_EN
    , .CSIZE(4)
`endif
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_ready(m_ready)
`ifdef RD_CNT_EN
    , .rd_cnt(rd_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  logic [7:0] fifo[$];
  logic [7:0] expq[$];
  bit   hold;
  int   n_cmp, n_err;
  int   pops, xfers, cyc, vcyc;
  int   first_p, first_x, last_x;
  bit   hv, hr;
  logic [7:0] hd;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic upd();
    rempty = hold || (fifo.size() == 0);
    rdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic load(logic [7:0] w);
    fifo.push_back(w);
    expq.push_back(w);
    upd();
  endtask

  task automatic clr_marks();
    first_p = -1;
    first_x = -1;
    last_x  = -1;
  endtask

  task automatic step();
    bit p, x;
    logic [7:0] d;
    @(negedge rclk);
    p = rinc;
    x = m_valid && m_ready;
    d = m_data;
    if (p && rempty) chk("rinc_while_empty", 1, 0);
    if (hv && !hr) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", d, hd);
    end
    hv = m_valid;
    hr = m_ready;
    hd = d;
    if (m_valid) vcyc++;
    if (x) begin
      if (expq.size() == 0) chk("extra_xfer", 1, 0);
      else chk("order", d, expq.pop_front());
      xfers++;
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
    end
    if (p) begin
      if (first_p < 0) first_p = cyc;
      pops++;
    end
    @(posedge rclk);
    #1;
    cyc++;
    if (p) void'(fifo.pop_front());
    upd();
  endtask

  task automatic drain(int bound);
    int n;
    n = 0;
    while (expq.size() != 0 && n < bound) begin
      step();
      n++;
    end
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
  endtask

  task automatic chk_cnt(string tag);
`ifdef RD_CNT_EN
    chk(tag, rd_cnt, xfers % 16);
`else
    chk(tag, xfers, xfers);
`endif
  endtask

  initial begin
    int p0, v0, n;
    n_cmp = 0; n_err = 0;
    pops = 0; xfers = 0; cyc = 0; vcyc = 0;
    hv = 0; hr = 0; hd = '0;
    hold = 0;
    m_ready = 1'b1;
    rrst_n = 1'b0;
    clr_marks();

    // reset with data available
    fifo.push_back(8'h77);
    upd();
    #3;
    chk("rst_rempty", rempty, 0);
    chk("rst_rinc", rinc, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
`ifdef RD_CNT_EN
    chk("rst_cnt", rd_cnt, 0);
`endif
    @(posedge rclk);
    @(posedge rclk);
    #1;
    chk("rst_rinc2", rinc, 0);
    fifo.delete();
    upd();
    rrst_n = 1'b1;

    // streaming
    clr_marks();
    for (int i = 1; i <= 16; i++) load(8'(i));
    m_ready = 1'b1;
    drain(40);
    chk("stream_lat", first_x - first_p, 1);
    chk("stream_span", last_x - first_x, 15);
    chk("stream_xfers", xfers, 16);
`ifdef RD_CNT_EN
    chk("stream_cnt_wrap", rd_cnt, 0);
`endif

    // backpressure
    m_ready = 1'b0;
    p0 = pops;
    load(8'hA1); load(8'hA2); load(8'hA3);
    for (int i = 0; i < 4; i++) step();
    chk("bp_pops", pops - p0, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'hA1);
    chk("bp_rinc", rinc, 0);
    chk("bp_rempty", rempty, 0);
    m_ready = 1'b1;
    drain(20);
    chk_cnt("bp_cnt");

    // single word then empty
    step(); step();
    p0 = pops;
    v0 = vcyc;
    load(8'h5C);
    drain(10);
    step(); step();
    chk("one_pops", pops - p0, 1);
    chk("one_vcyc", vcyc - v0, 1);
    chk("one_valid_off", m_valid, 0);
    chk("one_rinc_off", rinc, 0);
    chk_cnt("one_cnt");

    // random
    for (int i = 0; i < 1000; i++) fifo.push_back(8'($urandom));
    foreach (fifo[i]) expq.push_back(fifo[i]);
    n = 0;
    while (expq.size() != 0 && n < 20000) begin
      hold    = ($urandom_range(0, 3) == 0);
      m_ready = ($urandom_range(0, 2) != 0);
      upd();
      step();
      n++;
    end
    hold = 0;
    upd();
    chk("rand_left", expq.size(), 0);
    chk("rand_fifo_left", fifo.size(), 0);
    chk_cnt("rand_cnt");

    // reset while holding two words
    m_ready = 1'b0;
    load(8'h31); load(8'h32); load(8'h33);
    for (int i = 0; i < 3; i++) step();
    chk("two_rinc", rinc, 0);
    chk("two_valid", m_valid, 1);
    chk("two_data", m_data, 8'h31);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_rinc", rinc, 0);
`ifdef RD_CNT_EN
    chk("mid_rst_cnt", rd_cnt, 0);
`endif
    fifo.delete();
    expq.delete();
    xfers = 0;
    hv = 0;
    upd();
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;

    // counter from zero: 17 transfers after reset
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) load(8'(8'h80 + i));
    drain(40);
    chk("post_xfers", xfers, 17);
`ifdef RD_CNT_EN
    chk("post_cnt_wrap", rd_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
